// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the decode-stage fetch/branch controller.
// Provides the FSM state encoding and the sequential-PC helper.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {RUN, REDIRECT, WAIT_MEM, HALTED} fctrl_state_t;

  localparam int              PC_W   = 16;
  localparam logic [PC_W-1:0] PC_INC = 16'd2;

  // Fall-through address; wraps naturally at the top of the 16-bit space.
  function automatic logic [PC_W-1:0] seq_pc(input logic [PC_W-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_sat_counter.sv
// Saturating up-counter used for the controller's performance counters.
// Holds at all-ones instead of wrapping; cleared by synchronous active-low reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch resolution controller: checks fetch-time predictions against the
// resolved outcome, drives BHT/BTB writes and PC redirect, and sequences fetch/flush/halt.
module branch_resolve_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int FLUSH_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IF_ID_valid,
  input  logic [PC_W-1:0]  IF_ID_PC_curr,
  input  logic [1:0]       IF_ID_prediction,
  input  logic [PC_W-1:0]  IF_ID_predicted_target,
  input  logic             is_branch,
  input  logic             actual_taken,
  input  logic [PC_W-1:0]  actual_target,
  input  logic             hazard_stall,
  input  logic             imem_ready,
  input  logic             halt,
  output logic             wen_BHT,
  output logic             wen_BTB,
  output logic             update_PC,
  output logic [PC_W-1:0]  redirect_target,
  output logic             fetch_en,
  output logic             IF_ID_flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  fctrl_state_t state_q, state_d;
  logic [1:0]   flush_cnt_q, flush_cnt_d;

  logic eval;
  logic mispredicted;
  logic miscomputed;
  logic branch_inc;
  logic mispredict_inc;
  logic stall_inc;

  // Only the direction bit of the 2-bit BHT state matters here.
  logic unused_pred_lsb;
  assign unused_pred_lsb = IF_ID_prediction[0];

  always_comb begin
    eval         = (state_q == RUN) & IF_ID_valid & is_branch & ~hazard_stall & imem_ready;
    mispredicted = IF_ID_prediction[1] != actual_taken;
    miscomputed  = IF_ID_predicted_target != actual_target;

    wen_BHT         = eval & mispredicted;
    wen_BTB         = eval & (actual_taken | miscomputed);
    update_PC       = eval & ((actual_taken & (mispredicted | miscomputed)) |
                              (~actual_taken & IF_ID_prediction[1]));
    redirect_target = actual_taken ? actual_target : seq_pc(IF_ID_PC_curr);

    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    fetch_en    = 1'b0;
    IF_ID_flush = 1'b0;

    unique case (state_q)
      RUN: begin
        fetch_en    = ~hazard_stall & imem_ready;
        IF_ID_flush = update_PC;
        // A redirect outranks a memory wait and a halt on the wrong path.
        if (update_PC) begin
          state_d     = REDIRECT;
          flush_cnt_d = 2'(FLUSH_CYC);
        end else if (!imem_ready) begin
          state_d = WAIT_MEM;
        end else if (halt && IF_ID_valid && !hazard_stall) begin
          state_d = HALTED;
        end
      end
      REDIRECT: begin
        IF_ID_flush = 1'b1;
        fetch_en    = imem_ready;
        if (imem_ready) begin
          if (flush_cnt_q <= 2'd1) begin
            flush_cnt_d = 2'd0;
            state_d     = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 2'd1;
          end
        end
      end
      WAIT_MEM: begin
        if (imem_ready) begin
          state_d = RUN;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (!rst_n) begin
      wen_BHT         = 1'b0;
      wen_BTB         = 1'b0;
      update_PC       = 1'b0;
      redirect_target = '0;
      fetch_en        = 1'b0;
      IF_ID_flush     = 1'b1;
    end

    branch_inc     = eval & rst_n;
    mispredict_inc = update_PC;
    stall_inc      = ~fetch_en & (state_q != HALTED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      flush_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (branch_inc),
    .count (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mispredict_inc),
    .count (mispredict_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares every presented cycle.
module tb_branch_resolve_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          IF_ID_valid;
  logic [15:0]   IF_ID_PC_curr;
  logic [1:0]    IF_ID_prediction;
  logic [15:0]   IF_ID_predicted_target;
  logic          is_branch;
  logic          actual_taken;
  logic [15:0]   actual_target;
  logic          hazard_stall;
  logic          imem_ready;
  logic          halt;
  logic          wen_BHT;
  logic          wen_BTB;
  logic          update_PC;
  logic [15:0]   redirect_target;
  logic          fetch_en;
  logic          IF_ID_flush;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] mispredict_cnt;
  logic [CW-1:0] stall_cnt;

  branch_resolve_ctrl #(.CNT_W(CW), .FLUSH_CYC(1)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .IF_ID_valid            (IF_ID_valid),
    .IF_ID_PC_curr          (IF_ID_PC_curr),
    .IF_ID_prediction       (IF_ID_prediction),
    .IF_ID_predicted_target (IF_ID_predicted_target),
    .is_branch              (is_branch),
    .actual_taken           (actual_taken),
    .actual_target          (actual_target),
    .hazard_stall           (hazard_stall),
    .imem_ready             (imem_ready),
    .halt                   (halt),
    .wen_BHT                (wen_BHT),
    .wen_BTB                (wen_BTB),
    .update_PC              (update_PC),
    .redirect_target        (redirect_target),
    .fetch_en               (fetch_en),
    .IF_ID_flush            (IF_ID_flush),
    .branch_cnt             (branch_cnt),
    .mispredict_cnt         (mispredict_cnt),
    .stall_cnt              (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        bht;
    logic        btb;
    logic        upc;
    logic [15:0] tgt;
    logic        fen;
    logic        fl;
    logic [3:0]  bc;
    logic [3:0]  mc;
    logic [3:0]  sc;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         row_id = 0;
  logic [3:0] t_bc = 4'd0;
  logic [3:0] t_mc = 4'd0;
  logic [3:0] t_sc = 4'd0;

  function automatic logic [3:0] sinc(input logic [3:0] c, input logic en);
    return (en && c != 4'hF) ? c + 4'd1 : c;
  endfunction

  task automatic chk(input string nm, input int id, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row%0d %s got=%h want=%h", id, nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("wen_BHT",         e.id, {15'd0, wen_BHT},     {15'd0, e.bht});
      chk("wen_BTB",         e.id, {15'd0, wen_BTB},     {15'd0, e.btb});
      chk("update_PC",       e.id, {15'd0, update_PC},   {15'd0, e.upc});
      chk("redirect_target", e.id, redirect_target,      e.tgt);
      chk("fetch_en",        e.id, {15'd0, fetch_en},    {15'd0, e.fen});
      chk("IF_ID_flush",     e.id, {15'd0, IF_ID_flush}, {15'd0, e.fl});
      chk("branch_cnt",      e.id, {12'd0, branch_cnt},     {12'd0, e.bc});
      chk("mispredict_cnt",  e.id, {12'd0, mispredict_cnt}, {12'd0, e.mc});
      chk("stall_cnt",       e.id, {12'd0, stall_cnt},      {12'd0, e.sc});
    end
  end

  // Inputs, then hand-computed expected outputs; flags eev/ehal feed the counter tally.
  task automatic vec(input logic r, v, input logic [15:0] pc, input logic [1:0] pr,
                     input logic [15:0] pt, input logic b, t, input logic [15:0] at,
                     input logic h, rd, hl,
                     input logic ebht, ebtb, eupc, input logic [15:0] etgt,
                     input logic efen, efl, eev, ehal);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; IF_ID_valid = v; IF_ID_PC_curr = pc; IF_ID_prediction = pr;
    IF_ID_predicted_target = pt; is_branch = b; actual_taken = t; actual_target = at;
    hazard_stall = h; imem_ready = rd; halt = hl;
    e.id = row_id; e.bht = ebht; e.btb = ebtb; e.upc = eupc; e.tgt = etgt;
    e.fen = efen; e.fl = efl; e.bc = t_bc; e.mc = t_mc; e.sc = t_sc;
    sb_q.push_back(e);
    row_id++;
    if (!r) begin
      t_bc = 4'd0; t_mc = 4'd0; t_sc = 4'd0;
    end else begin
      t_bc = sinc(t_bc, eev);
      t_mc = sinc(t_mc, eupc);
      t_sc = sinc(t_sc, ~efen & ~ehal);
    end
  endtask

  task automatic idle(input logic rd, efen, efl, ehal);
    vec(1'b1, 1'b0, 16'h0000, 2'b00, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, rd, 1'b0,
        1'b0, 1'b0, 1'b0, 16'h0002, efen, efl, 1'b0, ehal);
  endtask

  task automatic rst_row();
    vec(1'b0, 1'b1, 16'h0010, 2'b00, 16'h0000, 1'b1, 1'b1, 16'h0020, 1'b0, 1'b1, 1'b0,
        1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Predicted not-taken, actually taken to 0x0090: full redirect.
  task automatic mispredict_0090();
    vec(1'b1, 1'b1, 16'h0010, 2'b00, 16'h0000, 1'b1, 1'b1, 16'h0090, 1'b0, 1'b1, 1'b0,
        1'b1, 1'b1, 1'b1, 16'h0090, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; IF_ID_valid = 1'b0; IF_ID_PC_curr = '0; IF_ID_prediction = '0;
    IF_ID_predicted_target = '0; is_branch = 1'b0; actual_taken = 1'b0; actual_target = '0;
    hazard_stall = 1'b0; imem_ready = 1'b1; halt = 1'b0;

    rst_row();
    rst_row();
    idle(1'b1, 1'b1, 1'b0, 1'b0);
    // Correct taken prediction, matching target.
    vec(1'b1, 1'b1, 16'h0008, 2'b11, 16'h0010, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b1, 1'b0,
        1'b0, 1'b1, 1'b0, 16'h0010, 1'b1, 1'b0, 1'b1, 1'b0);
    // Right direction, wrong target.
    vec(1'b1, 1'b1, 16'h0100, 2'b10, 16'h0030, 1'b1, 1'b1, 16'h0040, 1'b0, 1'b1, 1'b0,
        1'b0, 1'b1, 1'b1, 16'h0040, 1'b1, 1'b1, 1'b1, 1'b0);
    // Branch presented during REDIRECT is ignored.
    vec(1'b1, 1'b1, 16'h0040, 2'b00, 16'h0000, 1'b1, 1'b1, 16'h0050, 1'b0, 1'b1, 1'b0,
        1'b0, 1'b0, 1'b0, 16'h0050, 1'b1, 1'b1, 1'b0, 1'b0);
    // Predicted NT, taken to 0x0020; redirect stretched by one memory wait.
    vec(1'b1, 1'b1, 16'h0040, 2'b01, 16'h0000, 1'b1, 1'b1, 16'h0020, 1'b0, 1'b1, 1'b0,
        1'b1, 1'b1, 1'b1, 16'h0020, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b0, 1'b0);
    // Predicted T, not taken at 0xFFFE: fall-through wraps to 0x0000.
    vec(1'b1, 1'b1, 16'hFFFE, 2'b11, 16'h1234, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b1, 1'b0,
        1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b1, 1'b0);
    // Correct not-taken with stale target: BTB written, no redirect.
    vec(1'b1, 1'b1, 16'h0200, 2'b00, 16'h0300, 1'b1, 1'b0, 16'h0400, 1'b0, 1'b1, 1'b0,
        1'b0, 1'b1, 1'b0, 16'h0202, 1'b1, 1'b0, 1'b1, 1'b0);
    // Branch under hazard stall, then the same branch once the stall clears.
    vec(1'b1, 1'b1, 16'h0010, 2'b00, 16'h0000, 1'b1, 1'b1, 16'h0080, 1'b1, 1'b1, 1'b0,
        1'b0, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b0);
    vec(1'b1, 1'b1, 16'h0010, 2'b00, 16'h0000, 1'b1, 1'b1, 16'h0080, 1'b0, 1'b1, 1'b0,
        1'b1, 1'b1, 1'b1, 16'h0080, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b1, 1'b0);
    // Three cycles of imem_ready=0, then WAIT_MEM exit cycle.
    idle(1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b1, 1'b0, 1'b0);
    // Halt together with a mispredict: redirect wins.
    vec(1'b1, 1'b1, 16'h0030, 2'b00, 16'h0000, 1'b1, 1'b1, 16'h0060, 1'b0, 1'b1, 1'b1,
        1'b1, 1'b1, 1'b1, 16'h0060, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b0, 1'b0);
    // Real halt, then HALTED ignores a mispredicting branch and memory stalls.
    vec(1'b1, 1'b1, 16'h0500, 2'b00, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1,
        1'b0, 1'b0, 1'b0, 16'h0502, 1'b1, 1'b0, 1'b0, 1'b0);
    vec(1'b1, 1'b1, 16'h0010, 2'b00, 16'h0000, 1'b1, 1'b1, 16'h0070, 1'b0, 1'b1, 1'b0,
        1'b0, 1'b0, 1'b0, 16'h0070, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0, 1'b0, 1'b1);
    rst_row();
    // Reset in the middle of a redirect discards the pending flush.
    mispredict_0090();
    rst_row();
    idle(1'b1, 1'b1, 1'b0, 1'b0);
    // Twenty mispredicts drive the 4-bit counters into saturation.
    for (int i = 0; i < 20; i++) begin
      mispredict_0090();
      idle(1'b1, 1'b1, 1'b1, 1'b0);
    end
    idle(1'b1, 1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
